// File: rtl/lsu_word_port.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lsu_word_port : one RV32 load/store -> one masked word access, 2-entry rsp FIFO
// Optional performance counters: define LSU_PERF_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module lsu_word_port #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_rmask,
  output logic [3:0]       dmem_wmask,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_resp,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_store,
  output logic             rsp_err,
  output logic [31:0]      perf_loads,
  output logic [31:0]      perf_stores,
  output logic [31:0]      perf_stall
);

  logic             outst_q, outst_d;
  logic             outst_err_q, outst_err_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             store_q, store_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       a_q, a_d;

  logic [1:0]       count_q, count_d;
  logic             wr_q, rd_q;
  logic [31:0]      fdata_q  [0:1];
  logic [TAG_W-1:0] ftag_q   [0:1];
  logic             fstore_q [0:1];
  logic             ferr_q   [0:1];

  logic        done, mem_free, pop, accept, legal;
  logic [2:0]  occ;
  logic [3:0]  mask;
  logic [1:0]  a;
  logic [31:0] shifted, ldata, push_data;

  assign a         = req_addr[1:0];
  assign done      = outst_q && (outst_err_q || dmem_resp);
  assign mem_free  = !outst_q || done;
  assign rsp_valid = (count_q != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  // Occupancy after this edge must leave a slot for the completion of the new request.
  assign occ       = {1'b0, count_q} + {2'b00, done} - {2'b00, pop};
  assign req_ready = mem_free && (occ < 3'd2);
  assign accept    = req_valid && req_ready;

  always_comb begin
    legal = 1'b0;
    mask  = 4'b0000;
    case (req_funct3)
      3'b000: begin legal = 1'b1;                   mask = 4'b0001 << a; end
      3'b001: begin legal = !a[0];                  mask = 4'b0011 << a; end
      3'b010: begin legal = (a == 2'b00);           mask = 4'b1111;      end
      3'b100: begin legal = !req_store;             mask = 4'b0001 << a; end
      3'b101: begin legal = !req_store && !a[0];    mask = 4'b0011 << a; end
      default: ;
    endcase
  end

  assign dmem_addr  = {req_addr[31:2], 2'b00};
  assign dmem_wdata = req_wdata << {a, 3'b000};
  assign dmem_rmask = (accept && legal && !req_store) ? mask : 4'b0000;
  assign dmem_wmask = (accept && legal &&  req_store) ? mask : 4'b0000;

  always_comb begin
    outst_d     = outst_q;
    outst_err_d = outst_err_q;
    tag_d       = tag_q;
    store_d     = store_q;
    f3_d        = f3_q;
    a_d         = a_q;
    if (accept) begin
      outst_d     = 1'b1;
      outst_err_d = !legal;
      tag_d       = req_tag;
      store_d     = req_store;
      f3_d        = req_funct3;
      a_d         = a;
    end else if (done) begin
      outst_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q     <= 1'b0;
      outst_err_q <= 1'b0;
      tag_q       <= '0;
      store_q     <= 1'b0;
      f3_q        <= 3'b000;
      a_q         <= 2'b00;
    end else begin
      outst_q     <= outst_d;
      outst_err_q <= outst_err_d;
      tag_q       <= tag_d;
      store_q     <= store_d;
      f3_q        <= f3_d;
      a_q         <= a_d;
    end
  end

  assign shifted = dmem_rdata >> {a_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ldata = {{24{shifted[7]}},  shifted[7:0]};
      3'b001:  ldata = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ldata = {24'd0, shifted[7:0]};
      3'b101:  ldata = {16'd0, shifted[15:0]};
      default: ldata = shifted;
    endcase
  end

  assign push_data = (store_q || outst_err_q) ? 32'd0 : ldata;
  assign count_d   = count_q + {1'b0, done} - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      wr_q    <= wr_q ^ done;
      rd_q    <= rd_q ^ pop;
    end
  end

  // Storage needs no reset: outputs are gated by rsp_valid.
  always_ff @(posedge clk) begin
    if (done) begin
      fdata_q[wr_q]  <= push_data;
      ftag_q[wr_q]   <= tag_q;
      fstore_q[wr_q] <= store_q;
      ferr_q[wr_q]   <= outst_err_q;
    end
  end

  assign rsp_data  = rsp_valid ? fdata_q[rd_q]  : 32'd0;
  assign rsp_tag   = rsp_valid ? ftag_q[rd_q]   : '0;
  assign rsp_store = rsp_valid && fstore_q[rd_q];
  assign rsp_err   = rsp_valid && ferr_q[rd_q];

`ifdef LSU_PERF_EN
  logic [31:0] loads_q, stores_q, stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loads_q  <= 32'd0;
      stores_q <= 32'd0;
      stall_q  <= 32'd0;
    end else begin
      if (accept && legal && !req_store) loads_q  <= loads_q + 32'd1;
      if (accept && legal &&  req_store) stores_q <= stores_q + 32'd1;
      if (req_valid && !req_ready)       stall_q  <= stall_q + 32'd1;
    end
  end

  assign perf_loads  = loads_q;
  assign perf_stores = stores_q;
  assign perf_stall  = stall_q;
`else
  assign perf_loads  = 32'd0;
  assign perf_stores = 32'd0;
  assign perf_stall  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu_word_port.sv
`default_nettype none
// Testbench for lsu_word_port: directed vector table, corner sequences, random traffic.
module tb_lsu_word_port;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready, req_store;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr, req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]       dmem_rmask, dmem_wmask;
  logic             dmem_resp;
  logic             rsp_valid, rsp_ready, rsp_store, rsp_err;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      perf_loads, perf_stores, perf_stall;

  lsu_word_port #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_store(rsp_store), .rsp_err(rsp_err),
    .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             store;
    logic             err;
  } rsp_t;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic [31:0] ewd;
    logic        err;
    logic [31:0] edata;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mem_delay = 0;

  rsp_t exp_q[$];
  bit   infl = 0;
  rsp_t infl_r;

  logic [31:0] mem [0:255];
  bit          mp = 0;
  int          mcnt = 0;
  logic [31:0] mword;

  logic [31:0] m_loads = 0, m_stores = 0, m_stall = 0;

  bit          s_acc, s_pop;
  logic [3:0]  s_rmask, s_wmask;
  logic [31:0] s_wdata;
  rsp_t        pop_r;
  int          pop_tags[$];
  int          pop_cycs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void decode(input logic st, input logic [2:0] f3, input logic [1:0] a,
                                 output bit legal, output int size, output bit sgn);
    bit valid;
    valid = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    sgn   = !f3[2];
    legal = valid && (int'(a) % size == 0);
  endfunction

  // One clock cycle: entered just after a falling edge with inputs set; returns at the next falling edge.
  task automatic tick();
    bit          done, pop, rdy, acc, legal, sgn;
    int          size, v;
    logic [1:0]  a;
    logic [3:0]  m;
    logic [7:0]  idx;
    logic [31:0] w, sh_wd;
    rsp_t        r;

    if (mp && mcnt == 0) begin
      dmem_resp = 1'b1; dmem_rdata = mword; mp = 0;
    end else begin
      dmem_resp = 1'b0; dmem_rdata = $urandom;
      if (mp) mcnt--;
    end
    #1;
    done = infl && (infl_r.err || dmem_resp);
    pop  = (exp_q.size() > 0) && rsp_ready;
    rdy  = (!infl || done) && (exp_q.size() + int'(done) - int'(pop) < 2);
    check("req_ready", {31'd0, req_ready}, {31'd0, rdy});
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_q.size() > 0});
    s_pop = pop;
    if (pop) begin
      pop_r = exp_q[0];
      check("rsp_data",  rsp_data, pop_r.data);
      check("rsp_tag",   {27'd0, rsp_tag}, {27'd0, pop_r.tag});
      check("rsp_store", {31'd0, rsp_store}, {31'd0, pop_r.store});
      check("rsp_err",   {31'd0, rsp_err}, {31'd0, pop_r.err});
      pop_tags.push_back(int'(pop_r.tag));
      pop_cycs.push_back(cyc);
    end

    acc = req_valid && rdy;
    a   = req_addr[1:0];
    decode(req_store, req_funct3, a, legal, size, sgn);
    m     = 4'(((1 << size) - 1) << a);
    sh_wd = req_wdata << (8 * int'(a));
    check("dmem_rmask", {28'd0, dmem_rmask}, {28'd0, (acc && legal && !req_store) ? m : 4'd0});
    check("dmem_wmask", {28'd0, dmem_wmask}, {28'd0, (acc && legal &&  req_store) ? m : 4'd0});
    if (acc && legal) check("dmem_addr", dmem_addr, req_addr & 32'hFFFF_FFFC);
    if (acc && legal && req_store) check("dmem_wdata", dmem_wdata, sh_wd);
    s_acc   = req_valid && req_ready;
    s_rmask = dmem_rmask;
    s_wmask = dmem_wmask;
    s_wdata = dmem_wdata;

    if (pop) void'(exp_q.pop_front());
    if (done) begin exp_q.push_back(infl_r); infl = 0; end
    if (req_valid && !rdy) m_stall++;
    if (acc) begin
      idx = req_addr[9:2];
      r.tag = req_tag; r.store = req_store; r.err = !legal; r.data = 32'd0;
      if (legal && !req_store) begin
        w = mem[idx] >> (8 * int'(a));
        if (size == 4) r.data = w;
        else begin
          v = int'(w) & ((1 << (8 * size)) - 1);
          if (sgn && v >= (1 << (8 * size - 1))) v = v - (1 << (8 * size));
          r.data = 32'(v);
        end
      end
      infl = 1; infl_r = r;
      if (legal) begin
        if (req_store) m_stores++; else m_loads++;
        mword = mem[idx];
        if (req_store)
          for (int b = 0; b < 4; b++) if (m[b]) mem[idx][8*b +: 8] = sh_wd[8*b +: 8];
        mp = 1;
        mcnt = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    req_valid = 1'b0; rsp_ready = 1'b1;
    while ((infl || exp_q.size() > 0 || mp) && n < 60) begin tick(); n++; end
    checks++;
    if (n >= 60) begin errors++; $display("FAIL %s drain timeout actual=%0d required<60", name, n); end
  endtask

  task automatic check_perf(input string name);
`ifdef LSU_PERF_EN
    check({name, "_loads"},  perf_loads,  m_loads);
    check({name, "_stores"}, perf_stores, m_stores);
    check({name, "_stall"},  perf_stall,  m_stall);
`else
    check({name, "_loads"},  perf_loads,  32'd0);
    check({name, "_stores"}, perf_stores, 32'd0);
    check({name, "_stall"},  perf_stall,  32'd0);
`endif
  endtask

  vec_t tv[14];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    logic [31:0] stall_base;

    tv[0]  = '{1'b0, 3'b000, 32'h1003, 32'h0,        32'h80FF1234, 4'b1000, 4'b0000, 32'h0,        1'b0, 32'hFFFFFF80};
    tv[1]  = '{1'b1, 3'b001, 32'h2002, 32'h0000ABCD, 32'h0,        4'b0000, 4'b1100, 32'hABCD0000, 1'b0, 32'h0};
    tv[2]  = '{1'b0, 3'b010, 32'h3001, 32'h0,        32'h11111111, 4'b0000, 4'b0000, 32'h0,        1'b1, 32'h0};
    tv[3]  = '{1'b0, 3'b100, 32'h1001, 32'h0,        32'h80FF1234, 4'b0010, 4'b0000, 32'h0,        1'b0, 32'h00000012};
    tv[4]  = '{1'b0, 3'b001, 32'h1002, 32'h0,        32'h80FF1234, 4'b1100, 4'b0000, 32'h0,        1'b0, 32'hFFFF80FF};
    tv[5]  = '{1'b0, 3'b101, 32'h1002, 32'h0,        32'h80FF1234, 4'b1100, 4'b0000, 32'h0,        1'b0, 32'h000080FF};
    tv[6]  = '{1'b0, 3'b010, 32'h1000, 32'h0,        32'h80FF1234, 4'b1111, 4'b0000, 32'h0,        1'b0, 32'h80FF1234};
    tv[7]  = '{1'b0, 3'b001, 32'h1001, 32'h0,        32'h80FF1234, 4'b0000, 4'b0000, 32'h0,        1'b1, 32'h0};
    tv[8]  = '{1'b1, 3'b000, 32'h2001, 32'h123456A5, 32'h0,        4'b0000, 4'b0010, 32'h3456A500, 1'b0, 32'h0};
    tv[9]  = '{1'b1, 3'b010, 32'h2000, 32'hDEADBEEF, 32'h0,        4'b0000, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[10] = '{1'b0, 3'b011, 32'h1000, 32'h0,        32'h80FF1234, 4'b0000, 4'b0000, 32'h0,        1'b1, 32'h0};
    tv[11] = '{1'b1, 3'b100, 32'h2000, 32'h55555555, 32'h0,        4'b0000, 4'b0000, 32'h0,        1'b1, 32'h0};
    tv[12] = '{1'b0, 3'b000, 32'h1000, 32'h0,        32'h80FF1234, 4'b0001, 4'b0000, 32'h0,        1'b0, 32'h00000034};
    tv[13] = '{1'b0, 3'b101, 32'h1000, 32'h0,        32'h80FF1234, 4'b0011, 4'b0000, 32'h0,        1'b0, 32'h00001234};

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_tag = '0; rsp_ready = 1'b0;
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check_perf("rst_perf");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table, one request at a time with magic memory.
    for (int i = 0; i < 14; i++) begin
      mem[tv[i].addr[9:2]] = tv[i].word;
      req_valid = 1'b1; req_store = tv[i].st; req_funct3 = tv[i].f3;
      req_addr = tv[i].addr; req_wdata = tv[i].wdata; req_tag = TAG_W'(i);
      rsp_ready = 1'b1; mem_delay = 0;
      tick();
      check("tv_acc",   {31'd0, s_acc}, 32'd1);
      check("tv_rmask", {28'd0, s_rmask}, {28'd0, tv[i].rm});
      check("tv_wmask", {28'd0, s_wmask}, {28'd0, tv[i].wm});
      if (tv[i].st && !tv[i].err) check("tv_wdata", s_wdata, tv[i].ewd);
      req_valid = 1'b0;
      n = 0; got = 0;
      while (!got && n < 10) begin tick(); n++; got = s_pop; end
      check("tv_latency", n, 2);
      check("tv_data",  pop_r.data, tv[i].edata);
      check("tv_err",   {31'd0, pop_r.err}, {31'd0, tv[i].err});
      check("tv_store", {31'd0, pop_r.store}, {31'd0, tv[i].st});
      check("tv_tag",   {27'd0, pop_r.tag}, i);
    end
    drain("tv");
    check_perf("tv_perf");

    // Eight back-to-back LW, magic memory, always-ready consumer.
    pop_tags.delete(); pop_cycs.delete();
    rsp_ready = 1'b1; mem_delay = 0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
      req_addr = 32'h100 + 32'(4 * i); req_tag = TAG_W'(i);
      tick();
      check("b2b_ready", {31'd0, s_acc}, 32'd1);
    end
    drain("b2b");
    check("b2b_count", pop_tags.size(), 8);
    for (int i = 0; i < 8 && i < pop_tags.size(); i++) begin
      check("b2b_tag", pop_tags[i], i);
      check("b2b_gap", pop_cycs[i] - pop_cycs[0], i);
    end

    // Three loads against a stalled consumer.
    stall_base = m_stall;
    rsp_ready = 1'b0; req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010;
    for (int i = 0; i < 2; i++) begin
      req_addr = 32'h200 + 32'(4 * i); req_tag = TAG_W'(20 + i);
      tick();
      check("stall_early_acc", {31'd0, s_acc}, 32'd1);
    end
    req_addr = 32'h208; req_tag = TAG_W'(22);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_hold", {31'd0, s_acc}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("stall_release", {31'd0, s_acc}, 32'd1);
    check("stall_cycles", m_stall - stall_base, 32'd4);
    check_perf("stall_perf");
    drain("stall");

    // Reset while a load waits on a slow memory, with one entry already queued.
    rsp_ready = 1'b0; mem_delay = 0;
    req_valid = 1'b1; req_funct3 = 3'b010; req_addr = 32'h300; req_tag = TAG_W'(3);
    tick();
    req_valid = 1'b0; tick();
    mem_delay = 6;
    req_valid = 1'b1; req_addr = 32'h304; req_tag = TAG_W'(4);
    tick();
    req_valid = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("mrst_masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
    check("mrst_rsp_data", {rsp_data[31:6], rsp_tag, rsp_err}, 32'd0);
    infl = 0; exp_q.delete(); m_loads = 0; m_stores = 0; m_stall = 0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check_perf("mrst_perf");
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("mrst_stale", {31'd0, mp}, 32'd0);

    // Randomized traffic against the reference model.
    mem_delay = -1;
    for (int i = 0; i < 600; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_store  = $urandom_range(0, 1);
      req_funct3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : (req_store ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_tag    = TAG_W'($urandom);
      rsp_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("rand");
    check_perf("rand_perf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
